resp_checker: RTL and testbench

RESP_CHECKER -- requirements
Module: resp_checker

---
 rtl/resp_checker_pkg.sv | 22 ++
 rtl/resp_checker_fifo.sv | 66 ++++++
 rtl/resp_checker.sv | 176 +++++++++++++++++
 tb/tb_resp_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/resp_checker_pkg.sv
// resp_checker shared types and constants.
// State encoding, default sizes and the saturating counter helper.
package resp_checker_pkg;

  localparam int DEF_W       = 10;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_TIMEOUT = 1024;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/resp_checker_fifo.sv
// exp_fifo: expected-sample FIFO for resp_checker.
// Same-cycle push/pop always allowed; empty push+pop bypasses.
module exp_fifo
  import resp_checker_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign dout_o  = empty_o ? din_i : mem_q[rd_q];

  // an empty push+pop passes straight through and stores nothing
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i)
                   && !(empty_o && pop_i);

  // storage array, written only on an accepted push
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= din_i;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/resp_checker.sv
// resp_checker: compares filter responses against golden samples.
// Optional macro RESP_CHECKER_TOL_EN enables tolerance compare.
module resp_checker
  import resp_checker_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [CNT_W-1:0] N_SAMPLES,
  input  logic [2:0]       TOL,
  input  logic             EXP_V,
  input  logic [W-1:0]     EXP,
  input  logic             VIN,
  input  logic [W-1:0]     DIN,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             DONE,
  output logic             FAIL,
  output logic             OVF,
  output logic             UNF,
  output logic             TMO
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] rcv_q, rcv_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [TW-1:0]    idle_q, idle_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             tmo_q, tmo_d;

  logic         f_clr;
  logic         f_push;
  logic         f_pop;
  logic [W-1:0] head;
  logic         f_empty;
  logic         f_full;
  logic         pass;

  exp_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .clr_i   (f_clr),
    .push_i  (f_push),
    .pop_i   (f_pop),
    .din_i   (EXP),
    .dout_o  (head),
    .empty_o (f_empty),
    .full_o  (f_full)
  );

`ifdef RESP_CHECKER_TOL_EN
  logic signed [W:0] diff;
  logic [W:0]        mag;

  // W+1-bit signed difference cannot wrap
  always_comb begin
    diff = $signed({DIN[W-1], DIN})
         - $signed({head[W-1], head});
    mag  = diff[W] ? $unsigned(-diff)
                   : $unsigned(diff);
    pass = (mag <= {{(W-2){1'b0}}, TOL});
  end
`else
  logic unused_tol;
  assign unused_tol = ^TOL;
  assign pass = (DIN == head);
`endif

  // run control, FIFO steering, counters and flags
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    rcv_d   = rcv_q;
    match_d = match_q;
    err_d   = err_q;
    idle_d  = idle_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    tmo_d   = tmo_q;
    f_clr   = 1'b0;
    f_push  = 1'b0;
    f_pop   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_RUN;
          n_d     = N_SAMPLES;
          rcv_d   = '0;
          match_d = '0;
          err_d   = '0;
          idle_d  = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          tmo_d   = 1'b0;
          f_clr   = 1'b1;
        end
      end
      S_RUN: begin
        if (rcv_q == n_q) begin
          state_d = S_DONE;
        end else begin
          f_push = EXP_V;
          f_pop  = VIN;
          if (EXP_V && f_full && !VIN) ovf_d = 1'b1;
          if (VIN) begin
            rcv_d  = rcv_q + 1'b1;
            idle_d = '0;
            if (f_empty && !EXP_V) begin
              unf_d = 1'b1;
              err_d = sat_inc(err_q);
            end else if (pass) begin
              match_d = sat_inc(match_q);
            end else begin
              err_d = sat_inc(err_q);
            end
            if (rcv_q + 1'b1 == n_q) state_d = S_DONE;
          end else if (idle_q == TLIM) begin
            tmo_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      rcv_q   <= '0;
      match_q <= '0;
      err_q   <= '0;
      idle_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      rcv_q   <= rcv_d;
      match_q <= match_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      tmo_q   <= tmo_d;
    end
  end

  assign MATCH_CNT = match_q;
  assign ERR_CNT   = err_q;
  assign DONE      = (state_q == S_DONE);
  assign OVF       = ovf_q;
  assign UNF       = unf_q;
  assign TMO       = tmo_q;
  assign FAIL      = DONE && ((err_q != '0)
                     || ovf_q || unf_q || tmo_q);

endmodule

// File: tb/tb_resp_checker.sv
// tb_resp_checker: directed bench for resp_checker.
// Expected values depend on RESP_CHECKER_TOL_EN where relevant.
module tb_resp_checker;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [15:0] N_SAMPLES = '0;
  logic [2:0]  TOL = '0;
  logic        EXP_V = 1'b0;
  logic [9:0]  EXP = '0;
  logic        VIN = 1'b0;
  logic [9:0]  DIN = '0;
  logic [15:0] MATCH_CNT;
  logic [15:0] ERR_CNT;
  logic        DONE;
  logic        FAIL;
  logic        OVF;
  logic        UNF;
  logic        TMO;

  int checks = 0;
  int errors = 0;

  resp_checker #(
    .W       (10),
    .DEPTH   (8),
    .TIMEOUT (16)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .N_SAMPLES (N_SAMPLES),
    .TOL       (TOL),
    .EXP_V     (EXP_V),
    .EXP       (EXP),
    .VIN       (VIN),
    .DIN       (DIN),
    .MATCH_CNT (MATCH_CNT),
    .ERR_CNT   (ERR_CNT),
    .DONE      (DONE),
    .FAIL      (FAIL),
    .OVF       (OVF),
    .UNF       (UNF),
    .TMO       (TMO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic        st;
    logic [15:0] n;
    logic [2:0]  tol;
    logic        ev;
    int          e;
    logic        v;
    int          d;
    logic [15:0] mc;
    logic [15:0] ec;
    logic [4:0]  fl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input string nm, input logic st,
    input int n, input int tol,
    input logic ev, input int e,
    input logic v, input int d,
    input int mc, input int ec,
    input logic [4:0] fl
  );
    vec_t r;
    r.nm  = nm;
    r.st  = st;
    r.n   = 16'(n);
    r.tol = 3'(tol);
    r.ev  = ev;
    r.e   = e;
    r.v   = v;
    r.d   = d;
    r.mc  = 16'(mc);
    r.ec  = 16'(ec);
    r.fl  = fl;
    return r;
  endfunction

  task automatic drive(
    input logic st, input int n, input int tol,
    input logic ev, input int e,
    input logic v, input int d
  );
    @(negedge CLK);
    START     = st;
    N_SAMPLES = 16'(n);
    TOL       = 3'(tol);
    EXP_V     = ev;
    EXP       = 10'(e);
    VIN       = v;
    DIN       = 10'(d);
    @(posedge CLK);
    #1;
    START = 1'b0;
    EXP_V = 1'b0;
    VIN   = 1'b0;
  endtask

  // fl = {DONE, FAIL, OVF, UNF, TMO}
  task automatic check(
    input string nm, input int mc, input int ec,
    input logic [4:0] fl
  );
    logic [36:0] got;
    logic [36:0] want;
    got  = {MATCH_CNT, ERR_CNT,
            DONE, FAIL, OVF, UNF, TMO};
    want = {16'(mc), 16'(ec), fl};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got mc=%0d ec=%0d dfouT=%b want mc=%0d ec=%0d dfouT=%b",
               nm, MATCH_CNT, ERR_CNT,
               {DONE, FAIL, OVF, UNF, TMO},
               mc, ec, fl);
    end
  endtask

  initial begin
    tbl.push_back(mk("idle",      0,0,0, 0,0,   0,0,   0,0,5'b00000));
    tbl.push_back(mk("start4",    1,4,0, 0,0,   0,0,   0,0,5'b00000));
    tbl.push_back(mk("push10",    0,0,0, 1,10,  0,0,   0,0,5'b00000));
    tbl.push_back(mk("st_in_run", 1,1,0, 1,20,  0,0,   0,0,5'b00000));
    tbl.push_back(mk("push_m5",   0,0,0, 1,-5,  0,0,   0,0,5'b00000));
    tbl.push_back(mk("vin10",     0,0,0, 1,511, 1,10,  1,0,5'b00000));
    tbl.push_back(mk("vin20",     0,0,0, 0,0,   1,20,  2,0,5'b00000));
    tbl.push_back(mk("vin_m5",    0,0,0, 0,0,   1,-5,  3,0,5'b00000));
    tbl.push_back(mk("vin511",    0,0,0, 0,0,   1,511, 4,0,5'b10000));
    tbl.push_back(mk("done_hold", 0,0,0, 1,3,   1,0,   4,0,5'b10000));
    tbl.push_back(mk("start1",    1,1,2, 0,0,   0,0,   0,0,5'b00000));
    tbl.push_back(mk("push100",   0,0,2, 1,100, 0,0,   0,0,5'b00000));
`ifdef RESP_CHECKER_TOL_EN
    tbl.push_back(mk("tol102",    0,0,2, 0,0,   1,102, 1,0,5'b10000));
`else
    tbl.push_back(mk("exact102",  0,0,2, 0,0,   1,102, 0,1,5'b11000));
`endif
    tbl.push_back(mk("start3",    1,3,0, 0,0,   0,0,   0,0,5'b00000));
    tbl.push_back(mk("underflow", 0,0,0, 0,0,   1,7,   0,1,5'b00010));
    tbl.push_back(mk("bypass1",   0,0,0, 1,-3,  1,-3,  1,1,5'b00010));
    tbl.push_back(mk("bypass2",   0,0,0, 1,50,  1,50,  2,1,5'b11010));

    #2;
    check("reset_async", 0, 0, 5'b00000);
    #20;
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].st, int'(tbl[i].n),
            int'(tbl[i].tol), tbl[i].ev, tbl[i].e,
            tbl[i].v, tbl[i].d);
      check(tbl[i].nm, int'(tbl[i].mc),
            int'(tbl[i].ec), tbl[i].fl);
    end

    // overflow: ninth push is dropped
    drive(1, 8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, i * 3, 0, 0);
    check("ovf_flag", 0, 0, 5'b00100);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 1, i * 3);
    check("ovf_done", 8, 0, 5'b11100);

    // timeout after 16 idle cycles
    drive(1, 5, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 2, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 1, 2);
    check("tmo_two", 2, 0, 5'b00000);
    for (int i = 0; i < 15; i++) drive(0, 0, 0, 0, 0, 0, 0);
    check("tmo_not_yet", 2, 0, 5'b00000);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("tmo_hit", 2, 0, 5'b11001);

    // reset mid-run
    drive(1, 4, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 5);
    drive(0, 0, 0, 1, 6, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 6);
    check("pre_reset", 2, 0, 5'b00000);
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_reset", 0, 0, 5'b00000);
    @(negedge CLK);
    RST_N = 1'b1;
    drive(0, 0, 0, 1, 9, 1, 9);
    check("idle_ignores", 0, 0, 5'b00000);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("n0_start", 0, 0, 5'b00000);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("n0_done", 0, 0, 5'b10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
